// File: rtl/rain_frame_sequencer.sv
// Frame-rate controller for the glyph-rain datapath: run/pause, single-step, speed divider
// and frame-boundary palette switching, all clocked by the pixel clock.
module rain_frame_sequencer #(
    parameter int CNT_W            = 10,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int STEP_INC         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             run_en,
    input  logic             step_btn,
    input  logic [1:0]       speed,
    input  logic [1:0]       pal_sel,
    input  logic             auto_pal,
    output logic [CNT_W-1:0] anim_counter,
    output logic [1:0]       palette_id,
    output logic             frame_tick,
    output logic             paused
);

    typedef enum logic [1:0] {RUN, PAUSED, STEP_ARMED} state_t;

    localparam logic [CNT_W:0] INC = (CNT_W+1)'(STEP_INC);

    state_t          state;
    logic [2:0]      div_cnt;
    logic            vsync_q;
    logic [1:0]      run_sync, step_sync, auto_sync;
    logic [1:0][1:0] pal_sync;
    logic            step_q;

    logic            vs_act, frame_edge, step_rise, div_hit, adv;
    logic [3:0]      lim;
    logic [CNT_W:0]  sum;

    assign vs_act     = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign frame_edge = vs_act & ~vsync_q;
    assign step_rise  = step_sync[1] & ~step_q;
    assign lim        = (4'd1 << speed) - 4'd1;
    assign div_hit    = ({1'b0, div_cnt} >= lim);
    assign adv        = (state == RUN && div_hit) || (state == STEP_ARMED);
    assign sum        = {1'b0, anim_counter} + INC;
    assign paused     = (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // vsync_q follows the pin during reset so a vsync already asserted at release
            // is not mistaken for a fresh frame edge.
            vsync_q      <= vs_act;
            run_sync     <= '0;
            step_sync    <= '0;
            auto_sync    <= '0;
            pal_sync     <= '0;
            step_q       <= 1'b0;
            state        <= RUN;
            div_cnt      <= '0;
            anim_counter <= '0;
            palette_id   <= '0;
            frame_tick   <= 1'b0;
        end else begin
            vsync_q    <= vs_act;
            run_sync   <= {run_sync[0], run_en};
            step_sync  <= {step_sync[0], step_btn};
            auto_sync  <= {auto_sync[0], auto_pal};
            pal_sync   <= {pal_sync[0], pal_sel};
            step_q     <= step_sync[1];
            frame_tick <= frame_edge;

            if (frame_edge) begin
                if (adv)
                    anim_counter <= sum[CNT_W-1:0];

                if (auto_sync[1]) begin
                    if (adv && sum[CNT_W])
                        palette_id <= palette_id + 2'd1;
                end else begin
                    palette_id <= pal_sync[1];
                end

                case (state)
                    RUN: begin
                        div_cnt <= div_hit ? 3'd0 : div_cnt + 3'd1;
                        if (!run_sync[1])
                            state <= PAUSED;
                    end
                    PAUSED: begin
                        div_cnt <= '0;
                        // resuming at a tick swallows a coincident step
                        if (run_sync[1])
                            state <= RUN;
                        else if (step_rise)
                            state <= STEP_ARMED;
                    end
                    STEP_ARMED: begin
                        div_cnt <= '0;
                        state   <= run_sync[1] ? RUN : PAUSED;
                    end
                    default: begin
                        div_cnt <= '0;
                        state   <= RUN;
                    end
                endcase
            end else if (state == PAUSED && step_rise) begin
                state <= STEP_ARMED;
            end
        end
    end

endmodule

// File: tb/tb_rain_frame_sequencer.sv
// Scoreboard bench for rain_frame_sequencer: stimulus pushes model results per frame,
// a negedge monitor pops them on every frame_tick and checks stability between ticks.
module tb_rain_frame_sequencer;

    localparam int CW  = 4;
    localparam int INC = 1;
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b1;
    logic          run_en = 1'b0;
    logic          step_btn = 1'b0;
    logic [1:0]    speed = 2'd0;
    logic [1:0]    pal_sel = 2'd0;
    logic          auto_pal = 1'b0;
    logic [CW-1:0] anim_counter;
    logic [1:0]    palette_id;
    logic          frame_tick;
    logic          paused;

    rain_frame_sequencer #(.CNT_W(CW), .VSYNC_ACTIVE_LOW(1'b1), .STEP_INC(INC)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .run_en(run_en), .step_btn(step_btn),
        .speed(speed), .pal_sel(pal_sel), .auto_pal(auto_pal),
        .anim_counter(anim_counter), .palette_id(palette_id),
        .frame_tick(frame_tick), .paused(paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        int pal;
        int pz;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;

    // reference model: plain counters and flags describing the sequencer's behaviour
    int m_cnt = 0, m_pal = 0, m_div = 0;
    bit m_run = 1'b1, m_armed = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pal = 0; m_div = 0; m_run = 1'b1; m_armed = 1'b0;
    endtask

    task automatic model_tick();
        bit   adv;
        int   lim;
        int   sum;
        exp_t e;
        adv = 1'b0;
        lim = (1 << speed) - 1;
        if (m_run) begin
            if (m_div >= lim) begin adv = 1'b1; m_div = 0; end
            else m_div++;
            if (!run_en) m_run = 1'b0;
        end else if (m_armed) begin
            adv = 1'b1; m_armed = 1'b0; m_div = 0; m_run = run_en;
        end else begin
            m_div = 0; m_run = run_en;
        end
        sum   = m_cnt + (adv ? INC : 0);
        m_cnt = sum % MOD;
        if (auto_pal) begin
            if (sum >= MOD) m_pal = (m_pal + 1) % 4;
        end else begin
            m_pal = int'(pal_sel);
        end
        e.cyc = cyc + 1;
        e.cnt = m_cnt;
        e.pal = m_pal;
        e.pz  = m_run ? 0 : 1;
        sbq.push_back(e);
    endtask

    // one frame: settle inputs, optional step pulses, then a vsync pulse (active low)
    task automatic do_frame(input int gap, input int nsteps);
        wait_clk(4);
        for (int i = 0; i < nsteps; i++) begin
            step_btn = 1'b1;
            wait_clk(2);
            step_btn = 1'b0;
            wait_clk(2);
            if (!m_run) m_armed = 1'b1;
        end
        wait_clk(gap);
        vsync = 1'b0;
        model_tick();
        wait_clk(3);
        vsync = 1'b1;
    endtask

    // monitor: scoreboard on each tick, outputs must be frozen between ticks
    logic prev_tick = 1'b0;
    logic prev_rst_q = 1'b0;
    int   prev_cnt = 0, prev_pal = 0, prev_pz = 0;
    always @(negedge clk) begin
        exp_t e;
        if (frame_tick) begin
            check("tick_width", int'(prev_tick), 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got tick expected none (cyc %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("anim_counter", int'(anim_counter), e.cnt);
                check("palette_id", int'(palette_id), e.pal);
                check("paused", int'(paused), e.pz);
            end
        end else if (rst_q && prev_rst_q) begin
            check("anim_hold", int'(anim_counter), prev_cnt);
            check("pal_hold", int'(palette_id), prev_pal);
            check("paused_hold", int'(paused), prev_pz);
        end
        prev_tick  = frame_tick;
        prev_rst_q = rst_q;
        prev_cnt   = int'(anim_counter);
        prev_pal   = int'(palette_id);
        prev_pz    = int'(paused);
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        wait_clk(3);
        @(negedge clk);
        check("rst_anim", int'(anim_counter), 0);
        check("rst_pal", int'(palette_id), 0);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_paused", int'(paused), 0);
        wait_clk(1);
        rst_n = 1'b1;
        model_reset();

        // free run, speed 1
        run_en = 1'b1; speed = 2'd0;
        for (int i = 0; i < 3; i++) do_frame(5, 0);

        // speed 4 frames per advance
        speed = 2'd2;
        for (int i = 0; i < 8; i++) do_frame(5, 0);

        // pause mid-frame, then two steps in one frame give a single advance
        run_en = 1'b0;
        do_frame(5, 0);
        do_frame(4, 2);
        do_frame(4, 0);
        do_frame(4, 1);
        run_en = 1'b1;
        do_frame(4, 0);

        // manual palette change mid-frame
        speed = 2'd0; auto_pal = 1'b0; pal_sel = 2'd2;
        do_frame(6, 0);

        // counter to 15 with palette 3, then auto mode wraps both
        pal_sel = 2'd3;
        guard = 0;
        while (m_cnt != MOD - 1 && guard < 2 * MOD) begin do_frame(4, 0); guard++; end
        auto_pal = 1'b1;
        do_frame(4, 0);
        do_frame(4, 0);
        auto_pal = 1'b0; pal_sel = 2'd0;

        // mid-frame reset with counter at 5 and a vsync edge in the reset cycle
        guard = 0;
        while (m_cnt != 5 && guard < 2 * MOD) begin do_frame(4, 0); guard++; end
        wait_clk(3);
        rst_n = 1'b0;
        vsync = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_anim", int'(anim_counter), 0);
        check("midrst_pal", int'(palette_id), 0);
        check("midrst_tick", int'(frame_tick), 0);
        check("midrst_paused", int'(paused), 0);
        wait_clk(4);
        vsync = 1'b1;
        for (int i = 0; i < 3; i++) do_frame(4, 0);

        // randomized frames
        for (int i = 0; i < 150; i++) begin
            run_en   = ($urandom_range(0, 2) != 0);
            speed    = 2'($urandom_range(0, 3));
            pal_sel  = 2'($urandom_range(0, 3));
            auto_pal = ($urandom_range(0, 1) != 0);
            do_frame($urandom_range(4, 8), $urandom_range(0, 2));
        end

        wait_clk(6);
        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
